// File: rtl/tsc_check_scheduler.sv
// Round-robin scheduler that shares one two-rail checker tree between requesters,
// with periodic code / non-code self-test of the tree and sticky error reporting.
module tsc_check_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int TEST_PERIOD = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     test_en,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_x0,
    input  logic [NUM_REQ*WIDTH-1:0] req_y0,
    input  logic [NUM_REQ*WIDTH-1:0] req_x1,
    input  logic [NUM_REQ*WIDTH-1:0] req_y1,
    output logic [WIDTH-1:0]         chk_x0,
    output logic [WIDTH-1:0]         chk_y0,
    output logic [WIDTH-1:0]         chk_x1,
    output logic [WIDTH-1:0]         chk_y1,
    input  logic                     chk_f,
    input  logic                     chk_g,
    output logic                     res_valid,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                     res_ok,
    input  logic [NUM_REQ-1:0]       err_clr,
    output logic [NUM_REQ-1:0]       err_sticky,
    output logic                     st_fail,
    output logic                     st_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TEST_PERIOD);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TEST_PERIOD - 1);

    typedef enum logic [1:0] {S_SERVE = 2'd0, S_TA = 2'd1, S_TB = 2'd2} state_t;
    typedef enum logic [1:0] {TAG_USER = 2'd0, TAG_TA = 2'd1, TAG_TB = 2'd2} tag_t;

    // Alternating-bit test pattern with bit 0 clear (0xAAAA for 16 bits).
    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p[i] = 1'(i % 2);
        end
        return p;
    endfunction

    localparam logic [WIDTH-1:0] PAT_A = alt_pattern();

    state_t               state_r, state_s;
    logic [IDW-1:0]       ptr_r, ptr_s;
    logic [TW-1:0]        timer_r;
    logic                 pending_r;
    logic                 expire_s;
    logic                 sel_found_s;
    logic [IDW-1:0]       sel_idx_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic                 issue_s;
    tag_t                 kind_s;
    logic [IDW-1:0]       id_s;
    logic [WIDTH-1:0]     x0_s, y0_s, x1_s, y1_s;
    logic [WIDTH-1:0]     chk_x0_r, chk_y0_r, chk_x1_r, chk_y1_r;
    logic                 tag_valid_r;
    tag_t                 tag_kind_r;
    logic [IDW-1:0]       tag_id_r;
    logic                 res_valid_r, res_ok_r;
    logic [IDW-1:0]       res_id_r;
    logic [NUM_REQ-1:0]   err_sticky_r, err_set_s;
    logic                 st_fail_r;
    logic                 tree_ok_s;

    assign expire_s  = test_en && (timer_r == {TW{1'b0}});
    assign tree_ok_s = chk_f ^ chk_g;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            int idx_v;
            idx_v = (int'(ptr_r) + j) % NUM_REQ;
            if (!sel_found_s && req_valid[idx_v]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDW'(idx_v);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // FSM next state, grant and issue selection.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        grant_s = '0;
        issue_s = 1'b0;
        kind_s  = TAG_USER;
        id_s    = '0;
        x0_s    = chk_x0_r;
        y0_s    = chk_y0_r;
        x1_s    = chk_x1_r;
        y1_s    = chk_y1_r;
        case (state_r)
            S_SERVE: begin
                if (pending_r) begin
                    state_s = S_TA;
                end else begin
                    if (sel_found_s) begin
                        grant_s[sel_idx_s] = 1'b1;
                        issue_s = 1'b1;
                        id_s    = sel_idx_s;
                        x0_s    = req_x0[sel_idx_s*WIDTH +: WIDTH];
                        y0_s    = req_y0[sel_idx_s*WIDTH +: WIDTH];
                        x1_s    = req_x1[sel_idx_s*WIDTH +: WIDTH];
                        y1_s    = req_y1[sel_idx_s*WIDTH +: WIDTH];
                        ptr_s   = (sel_idx_s == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : sel_idx_s + 1'b1;
                    end else begin
                        ptr_s = ptr_r;
                    end
                    // An expiry alongside a grant lets the grant finish, test starts next cycle.
                    state_s = expire_s ? S_TA : S_SERVE;
                end
            end
            S_TA: begin
                issue_s = 1'b1;
                kind_s  = TAG_TA;
                x0_s    = PAT_A;
                y0_s    = ~PAT_A;
                x1_s    = ~PAT_A;
                y1_s    = PAT_A;
                state_s = S_TB;
            end
            S_TB: begin
                issue_s = 1'b1;
                kind_s  = TAG_TB;
                x0_s    = PAT_A;
                y0_s    = {~PAT_A[WIDTH-1:1], PAT_A[0]};
                x1_s    = ~PAT_A;
                y1_s    = PAT_A;
                state_s = S_SERVE;
            end
            default: begin
                state_s = S_SERVE;
            end
        endcase
    end

    // FSM state and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_SERVE;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // Self-test period timer and pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r   <= TIMER_LOAD;
            pending_r <= 1'b0;
        end else if (!test_en) begin
            timer_r   <= TIMER_LOAD;
            pending_r <= 1'b0;
        end else if (expire_s) begin
            timer_r   <= TIMER_LOAD;
            pending_r <= 1'b1;
        end else begin
            timer_r   <= timer_r - 1'b1;
            pending_r <= (state_r == S_TA) ? 1'b0 : pending_r;
        end
    end

    // Operand register towards the tree plus the tag travelling with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_x0_r    <= '0;
            chk_y0_r    <= '0;
            chk_x1_r    <= '0;
            chk_y1_r    <= '0;
            tag_valid_r <= 1'b0;
            tag_kind_r  <= TAG_USER;
            tag_id_r    <= '0;
        end else begin
            chk_x0_r    <= x0_s;
            chk_y0_r    <= y0_s;
            chk_x1_r    <= x1_s;
            chk_y1_r    <= y1_s;
            tag_valid_r <= issue_s;
            tag_kind_r  <= kind_s;
            tag_id_r    <= id_s;
        end
    end

    // Error flag set request from a user result that is not a code word.
    always_comb begin
        err_set_s = '0;
        if (tag_valid_r && (tag_kind_r == TAG_USER) && !tree_ok_s) begin
            err_set_s[tag_id_r] = 1'b1;
        end else begin
            err_set_s = '0;
        end
    end

    // Result strobe, sticky per-requester errors and sticky self-test failure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r  <= 1'b0;
            res_id_r     <= '0;
            res_ok_r     <= 1'b0;
            err_sticky_r <= '0;
            st_fail_r    <= 1'b0;
        end else begin
            res_valid_r  <= tag_valid_r && (tag_kind_r == TAG_USER);
            if (tag_valid_r && (tag_kind_r == TAG_USER)) begin
                res_id_r <= tag_id_r;
                res_ok_r <= tree_ok_s;
            end else begin
                res_id_r <= res_id_r;
                res_ok_r <= res_ok_r;
            end
            err_sticky_r <= err_set_s | (err_sticky_r & ~err_clr);
            if (tag_valid_r && (((tag_kind_r == TAG_TA) && !tree_ok_s) ||
                                ((tag_kind_r == TAG_TB) && tree_ok_s))) begin
                st_fail_r <= 1'b1;
            end else begin
                st_fail_r <= st_fail_r;
            end
        end
    end

    assign req_ready  = grant_s;
    assign chk_x0     = chk_x0_r;
    assign chk_y0     = chk_y0_r;
    assign chk_x1     = chk_x1_r;
    assign chk_y1     = chk_y1_r;
    assign res_valid  = res_valid_r;
    assign res_id     = res_id_r;
    assign res_ok     = res_ok_r;
    assign err_sticky = err_sticky_r;
    assign st_fail    = st_fail_r;
    assign st_busy    = (state_r != S_SERVE) || (tag_valid_r && (tag_kind_r != TAG_USER));

endmodule

// File: tb/tb_tsc_check_scheduler.sv
// Directed bench for tsc_check_scheduler with a behavioural two-rail checker tree.
module tb_tsc_check_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_en;
    logic [3:0]  req_valid, req_ready, err_clr, err_sticky;
    logic [63:0] req_x0, req_y0, req_x1, req_y1;
    logic [15:0] chk_x0, chk_y0, chk_x1, chk_y1;
    logic        chk_f, chk_g;
    logic        res_valid, res_ok, st_fail, st_busy;
    logic [1:0]  res_id;
    logic        stuck;
    logic        code_s;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    // Tree model: good tree answers (f,g)=(0,1) for code words and (0,0) otherwise.
    assign code_s = (chk_y0 == ~chk_x0) && (chk_y1 == ~chk_x1);
    assign chk_f  = 1'b0;
    assign chk_g  = stuck | code_s;

    tsc_check_scheduler #(.NUM_REQ(4), .WIDTH(16), .TEST_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n), .test_en(test_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .chk_x0(chk_x0), .chk_y0(chk_y0), .chk_x1(chk_x1), .chk_y1(chk_y1),
        .chk_f(chk_f), .chk_g(chk_g),
        .res_valid(res_valid), .res_id(res_id), .res_ok(res_ok),
        .err_clr(err_clr), .err_sticky(err_sticky),
        .st_fail(st_fail), .st_busy(st_busy)
    );

    task automatic set_raw(input int i, input logic [15:0] x0, input logic [15:0] y0,
                           input logic [15:0] x1, input logic [15:0] y1);
        req_x0[i*16 +: 16] = x0;
        req_y0[i*16 +: 16] = y0;
        req_x1[i*16 +: 16] = x1;
        req_y1[i*16 +: 16] = y1;
    endtask

    task automatic set_code(input int i, input logic [15:0] x0, input logic [15:0] x1);
        set_raw(i, x0, ~x0, x1, ~x1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'h0; err_clr = 4'h0; test_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [83:0] all_out;
        rst_n = 1'b0; test_en = 1'b0; req_valid = 4'h0; err_clr = 4'h0; stuck = 1'b0;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        repeat (2) @(negedge clk);
        #1;
        all_out = {req_ready, chk_x0, chk_y0, chk_x1, chk_y1, res_valid, res_id, res_ok,
                   err_sticky, st_fail, st_busy};
        tests_run++;
        if (all_out !== 84'h0) begin tests_failed++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_code(2, 16'h1234, 16'h00FF);
        req_valid = 4'b0100;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        tests_run++;
        if ({chk_x0, chk_y0, chk_x1, chk_y1} !== 64'h1234_EDCB_00FF_FF00) begin
            tests_failed++; $display("FAIL single_operands: got %h expected 1234edcb00ffff00", {chk_x0, chk_y0, chk_x1, chk_y1});
        end
        tests_run++;
        if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_res: got %b expected 0", res_valid); end
        @(negedge clk);
        #1;
        tests_run++;
        if ({res_valid, res_id, res_ok, err_sticky} !== {1'b1, 2'd2, 1'b1, 4'h0}) begin
            tests_failed++; $display("FAIL single_result: got v=%b id=%0d ok=%b err=%b expected v=1 id=2 ok=1 err=0000",
                                     res_valid, res_id, res_ok, err_sticky);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_strobe_len: got %b expected 0", res_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) set_code(k, 16'h0100 + 16'(k), 16'h3C3C);
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'(1 << (i % 4))) begin
                tests_failed++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, 4'(1 << (i % 4)));
            end
            if (i >= 2) begin
                tests_run++;
                if ({res_valid, res_id, res_ok} !== {1'b1, 2'((i - 2) % 4), 1'b1}) begin
                    tests_failed++; $display("FAIL rr_result[%0d]: got v=%b id=%0d ok=%b expected v=1 id=%0d ok=1",
                                             i, res_valid, res_id, res_ok, (i - 2) % 4);
                end
            end
            @(negedge clk);
        end
        req_valid = 4'h0;
        for (int i = 8; i < 10; i++) begin
            #1;
            tests_run++;
            if ({res_valid, res_id} !== {1'b1, 2'((i - 2) % 4)}) begin
                tests_failed++; $display("FAIL rr_drain[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, res_valid, res_id, (i - 2) % 4);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_idle: got %b expected 0", res_valid); end
    endtask

    task automatic test_error_flag();
        set_raw(1, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF);
        req_valid = 4'b0010;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL err_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({res_valid, res_id, res_ok, err_sticky} !== {1'b1, 2'd1, 1'b0, 4'b0010}) begin
            tests_failed++; $display("FAIL err_result: got v=%b id=%0d ok=%b err=%b expected v=1 id=1 ok=0 err=0010",
                                     res_valid, res_id, res_ok, err_sticky);
        end
        err_clr = 4'b0010;
        @(negedge clk);
        err_clr = 4'h0;
        #1;
        tests_run++;
        if (err_sticky !== 4'h0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0000", err_sticky); end
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'h0;
        err_clr = 4'b0010;
        @(negedge clk);
        err_clr = 4'h0;
        #1;
        tests_run++;
        if (err_sticky !== 4'b0010) begin tests_failed++; $display("FAIL err_set_wins: got %b expected 0010", err_sticky); end
        err_clr = 4'b0010;
        @(negedge clk);
        err_clr = 4'h0;
    endtask

    task automatic test_self_test();
        int   exp_ptr;
        int   hist [0:19];
        logic [3:0] exp_ready;
        logic blocked, exp_busy, exp_rv;
        do_reset();
        for (int k = 0; k < 4; k++) set_code(k, 16'h5000 + 16'(k), 16'h0F0F);
        req_valid = 4'hF;
        test_en = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            blocked = (i >= 8) && (((i % 8) == 0) || ((i % 8) == 1));
            if (blocked) begin
                exp_ready = 4'h0; hist[i] = -1;
            end else begin
                exp_ready = 4'(1 << exp_ptr); hist[i] = exp_ptr; exp_ptr = (exp_ptr + 1) % 4;
            end
            exp_busy = (i >= 8) && ((i % 8) <= 2);
            exp_rv = 1'b0;
            if (i >= 2) exp_rv = (hist[i-2] >= 0);
            tests_run++;
            if ({req_ready, st_busy} !== {exp_ready, exp_busy}) begin
                tests_failed++; $display("FAIL st_slot[%0d]: got ready=%b busy=%b expected ready=%b busy=%b",
                                         i, req_ready, st_busy, exp_ready, exp_busy);
            end
            tests_run++;
            if (res_valid !== exp_rv) begin
                tests_failed++; $display("FAIL st_res_valid[%0d]: got %b expected %b", i, res_valid, exp_rv);
            end
            if (exp_rv) begin
                tests_run++;
                if (res_id !== 2'(hist[i-2])) begin
                    tests_failed++; $display("FAIL st_res_id[%0d]: got %0d expected %0d", i, res_id, hist[i-2]);
                end
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (st_fail !== 1'b0) begin tests_failed++; $display("FAIL st_good_tree: got %b expected 0", st_fail); end
        test_en = 1'b0;
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stuck_tree();
        do_reset();
        stuck = 1'b1;
        test_en = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        tests_run++;
        if (st_fail !== 1'b0) begin tests_failed++; $display("FAIL stuck_before: got %b expected 0", st_fail); end
        @(negedge clk);
        #1;
        tests_run++;
        if (st_fail !== 1'b1) begin tests_failed++; $display("FAIL stuck_detect: got %b expected 1", st_fail); end
        test_en = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        tests_run++;
        if (st_fail !== 1'b1) begin tests_failed++; $display("FAIL stuck_sticky: got %b expected 1", st_fail); end
        do_reset();
        stuck = 1'b0;
        #1;
        tests_run++;
        if (st_fail !== 1'b0) begin tests_failed++; $display("FAIL stuck_reset_clear: got %b expected 0", st_fail); end
    endtask

    task automatic test_reset_inflight();
        logic [83:0] all_out;
        do_reset();
        set_code(2, 16'hBEEF, 16'h1111);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'h0;
        rst_n = 1'b0;
        #1;
        all_out = {req_ready, chk_x0, chk_y0, chk_x1, chk_y1, res_valid, res_id, res_ok,
                   err_sticky, st_fail, st_busy};
        tests_run++;
        if (all_out !== 84'h0) begin tests_failed++; $display("FAIL inflight_outputs: got %h expected 0", all_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL inflight_no_res[%0d]: got %b expected 0", i, res_valid); end
            @(negedge clk);
        end
        req_valid = 4'hF;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL inflight_first_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_error_flag();
        test_self_test();
        test_stuck_tree();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/tsc_check_scheduler.md
Name: tsc_check_scheduler

Overview:
- Shares one external WIDTH-bit two-rail checker tree between NUM_REQ requesters. Arbitration is round-robin.
- Checker tree is combinational: inputs x0/y0/x1/y1, outputs f/g. A word is a valid code when y0=~x0 and y1=~x1. The tree's output is a valid code when g=~f.
- Periodically preempts requesters to self-test the tree with one code word and one non-code word.
- Latches per-requester error flags and a sticky self-test failure flag.
- Sits between operand producers and the checker tree in the self-checking datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, checker operand width per rail.
- TEST_PERIOD, 256, cycles between self-test starts (>=4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- test_en  in  1  enables periodic self-test.
- req_valid  in  NUM_REQ  requester i has an operand set.
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid&ready.
- req_x0, req_y0, req_x1, req_y1  in  NUM_REQ*WIDTH each  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- chk_x0, chk_y0, chk_x1, chk_y1  out  WIDTH each  registered operands to the checker tree.
- chk_f, chk_g  in  1 each  checker tree outputs.
- res_valid  out  1  result strobe.
- res_id  out  $clog2(NUM_REQ)  requester index of the result.
- res_ok  out  1  1 when chk_f != chk_g.
- err_clr  in  NUM_REQ  clears err_sticky[i].
- err_sticky  out  NUM_REQ  requester i produced a non-code result.
- st_fail  out  1  sticky: checker tree failed self-test.
- st_busy  out  1  self-test in progress.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, including chk_* operands and res_*.
  - FSM goes to S_SERVE. RR pointer goes to 0. Test timer loads TEST_PERIOD-1. test_pending is 0.
  - Reset mid-operation discards in-flight issues; no res_valid is produced for them.
- Timer:
  - While test_en=1, the timer decrements every cycle.
  - At 0 it sets test_pending and reloads TEST_PERIOD-1.
  - While test_en=0, the timer holds at TEST_PERIOD-1 and test_pending clears.
- FSM S_SERVE:
  - If test_pending=1, req_ready is all 0 and the FSM goes to S_TA.
  - Otherwise req_ready is combinational and one-hot. It selects the first valid requester starting at the RR pointer, wrapping.
  - On a transfer from requester k: the operands register onto chk_*, the tag is {user,k}, and the pointer becomes (k+1) mod NUM_REQ.
  - No valid requester: no issue; the pointer is unchanged.
  - Maximum one issue per cycle, so a busy requester set gets back-to-back issues.
- FSM S_TA:
  - Issues the code word x0=0xAAAA-pattern (alternating bits, bit0=0), y0=~x0, x1=~x0, y1=x0.
  - Tag is test-A. test_pending clears. Next state is S_TB.
- FSM S_TB:
  - Issues a non-code word: same as S_TA except y0[0]=x0[0] (both 0). Tag is test-B.
  - Next state is S_SERVE.
- st_busy is 1 in S_TA and S_TB, and while either test issue is in flight.
- Pipeline timing:
  - Issue in cycle N: chk_* is valid in cycle N+1.
  - chk_f/chk_g are sampled at the end of N+1 with the tag from the stage-2 register.
  - Results appear in cycle N+2. Fixed latency: 2 cycles from the transfer edge.
- User tag results:
  - res_valid=1, res_id=k, res_ok=(chk_f^chk_g) for one cycle.
  - If res_ok=0, err_sticky[k] sets.
  - err_clr[k] clears err_sticky[k]; a set in the same cycle wins.
- Test tags: res_valid is not asserted.
  - test-A with chk_f==chk_g sets st_fail.
  - test-B with chk_f!=chk_g sets st_fail.
  - st_fail clears only on reset.
- chk_* holds the last issued value when there is no issue. The tag valid bit clears, so no result is produced.
- Simultaneous events:
  - Timer expiry in the same cycle as a grant: the grant completes, and the test starts next cycle.
  - Timer expiry while in S_TA/S_TB: test_pending sets again, and the next test runs after at least one S_SERVE cycle. Requesters are not starved beyond 2 cycles per period.
- test_en deasserted mid-test: the test already started completes normally.

Test Plan:
- Reset, test_en=0, only req 2 valid with a code word (y0=~x0, y1=~x1) and a good tree model:
  - req_ready[2]=1 in cycle 1.
  - res_valid=1, res_id=2, res_ok=1 two cycles later; err_sticky=0.
- All 4 requesters held valid:
  - Grants go 0,1,2,3,0,... on consecutive cycles.
  - res_id follows the same order at 2-cycle latency.
- Req 1 issues x0=y0=0x0001 (non-code):
  - res_ok=0 and err_sticky[1]=1.
  - err_clr[1] pulse clears it.
  - err_clr coinciding with a new error leaves the flag at 1.
- test_en=1, TEST_PERIOD=8, all requesters valid, good tree:
  - Every 8 cycles req_ready is 0 for 2 cycles and st_busy asserts.
  - No res_valid results for the test slots; st_fail stays 0.
- Tree model forced with f stuck at 0 and g stuck at 1:
  - After the first self-test, test-B passes through as a valid code, so st_fail=1.
  - st_fail stays 1 until rst_n is asserted.
- Assert rst_n low while an issue is in flight:
  - No res_valid follows. All outputs read 0.
  - After release, the first grant goes to req 0.
